// File: rtl/csa_in_dispatch_if.sv
// Interface bundling the FIFO-side read port, the calc-instance start/busy
// handshake and the dispatch status/statistics outputs of csa_in_dispatch.
// The "master" modport is the dispatcher's view; "slave" is the environment
// (FIFO + calc instances + status consumer).
interface csa_in_dispatch_if #(
  parameter int AXI_DATA_WIDTH          = 32,
  parameter int CSA_IN_PARAMETER_LENGTH = 160,
  parameter int CSA_CALC_INST_NUM       = 4
);

  // FIFO side
  logic                               csa_in_r_ready;
  logic                               csa_in_ren;
  logic [AXI_DATA_WIDTH-1:0]          csa_in_rdata;

  // calc-instance side
  logic [CSA_CALC_INST_NUM-1:0]       calc_busy;
  logic [CSA_CALC_INST_NUM-1:0]       calc_start;
  logic [CSA_IN_PARAMETER_LENGTH-1:0] calc_param;

  // status / statistics
  logic                               dispatch_stall;
  logic [31:0]                        stat_dispatch_cnt;
  logic [31:0]                        stat_stall_cnt;

  modport master (
    input  csa_in_r_ready,
    input  csa_in_rdata,
    input  calc_busy,
    output csa_in_ren,
    output calc_start,
    output calc_param,
    output dispatch_stall,
    output stat_dispatch_cnt,
    output stat_stall_cnt
  );

  modport slave (
    output csa_in_r_ready,
    output csa_in_rdata,
    output calc_busy,
    input  csa_in_ren,
    input  calc_start,
    input  calc_param,
    input  dispatch_stall,
    input  stat_dispatch_cnt,
    input  stat_stall_cnt
  );

endinterface

// File: rtl/csa_in_dispatch.sv
// csa_in_dispatch: pops one bulk of WORDS FIFO words, assembles them into a
// CSA input parameter (word k -> bits [k*W +: W]) and hands it to the first
// free calc instance found round-robin, with a one-cycle start pulse.
//
// Optional feature: define CSA_IN_DISPATCH_STAT_EN to build the 32-bit
// dispatch and stall-cycle counters; otherwise both stat ports are tied to 0.
module csa_in_dispatch #(
  parameter int AXI_DATA_WIDTH          = 32,
  parameter int CSA_IN_PARAMETER_LENGTH = 160,
  parameter int CSA_CALC_INST_NUM       = 4
) (
  input  logic              csa_calc_clk,
  input  logic              rst_n,
  csa_in_dispatch_if.master bus
);

  localparam int WORDS = CSA_IN_PARAMETER_LENGTH / AXI_DATA_WIDTH;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PTR_W = (CSA_CALC_INST_NUM > 1) ? $clog2(CSA_CALC_INST_NUM) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    WAIT_LAST = 3'd2,
    SELECT    = 3'd3,
    START     = 3'd4
  } state_t;

  state_t                             r_state;
  state_t                             w_state_nxt;
  logic [CNT_W-1:0]                   r_word_cnt;
  logic [CNT_W-1:0]                   r_cap_idx;
  logic                               r_ren_d;
  logic [PTR_W-1:0]                   r_rr_ptr;
  logic [PTR_W-1:0]                   r_sel;
  logic [CSA_IN_PARAMETER_LENGTH-1:0] r_param;

  logic                               w_ren;
  logic                               w_found;
  logic [PTR_W-1:0]                   w_pick;
  logic [PTR_W:0]                     w_idx;
  logic                               w_stall;
  logic [PTR_W-1:0]                   w_rr_nxt;

  // FSM state register
  // NOTE: sequential state is written with non-blocking (<=) so every flop samples pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge csa_calc_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: r_ready only matters in IDLE; SELECT holds until an instance is free
  // NOTE: the default assignment at the top keeps this block latch-free; any path that skipped a write would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:      if (bus.csa_in_r_ready) w_state_nxt = READ;
      READ:      if (r_word_cnt == CNT_W'(WORDS - 1)) w_state_nxt = WAIT_LAST;
      WAIT_LAST: w_state_nxt = SELECT;
      SELECT:    if (w_found) w_state_nxt = START;
      START:     w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Round-robin search: first non-busy instance at or after r_rr_ptr, wrapping
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 0; k < CSA_CALC_INST_NUM; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (PTR_W + 1)'(k);
      if (w_idx >= (PTR_W + 1)'(CSA_CALC_INST_NUM)) w_idx = w_idx - (PTR_W + 1)'(CSA_CALC_INST_NUM);
      if (!w_found && !bus.calc_busy[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[PTR_W-1:0];
      end
    end
  end

  // Pointer advance after a start: (sel + 1) mod N
  assign w_rr_nxt = (r_sel == PTR_W'(CSA_CALC_INST_NUM - 1)) ? '0 : r_sel + PTR_W'(1);

  // Glitch-free outputs: pure decodes of the registered state / selection
  assign w_ren              = (r_state == READ);
  assign w_stall            = (r_state == SELECT) && !w_found;
  assign bus.csa_in_ren     = w_ren;
  assign bus.dispatch_stall = w_stall;
  assign bus.calc_start     = (r_state == START) ? (CSA_CALC_INST_NUM'(1) << r_sel) : '0;
  assign bus.calc_param     = r_param;

  // Datapath: word counter, delayed pop qualifier, word capture, selection and rr pointer
  // NOTE: r_param is a single wide register, not a memory array, so it takes the async reset like every other output-facing flop.
  always_ff @(posedge csa_calc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
      r_cap_idx  <= '0;
      r_ren_d    <= 1'b0;
      r_rr_ptr   <= '0;
      r_sel      <= '0;
      r_param    <= '0;
    end else begin
      // Read data returns one cycle after the pop, so remember which slot it belongs to
      r_ren_d   <= w_ren;
      r_cap_idx <= r_word_cnt;

      if (r_state == IDLE) begin
        r_word_cnt <= '0;
      end else if (r_state == READ && r_word_cnt != CNT_W'(WORDS - 1)) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end

      if (r_ren_d) begin
        r_param[int'(r_cap_idx) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= bus.csa_in_rdata;
      end

      // Selection uses calc_busy as seen at the deciding edge
      if (r_state == SELECT && w_found) r_sel <= w_pick;

      if (r_state == START) r_rr_ptr <= w_rr_nxt;
    end
  end

`ifdef CSA_IN_DISPATCH_STAT_EN
  logic [31:0] r_stat_dispatch_cnt;
  logic [31:0] r_stat_stall_cnt;

  // Statistics: dispatches and stall cycles, free-running with natural 32-bit wrap
  always_ff @(posedge csa_calc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_dispatch_cnt <= '0;
      r_stat_stall_cnt    <= '0;
    end else begin
      if (r_state == START) r_stat_dispatch_cnt <= r_stat_dispatch_cnt + 32'd1;
      if (w_stall)          r_stat_stall_cnt    <= r_stat_stall_cnt + 32'd1;
    end
  end

  assign bus.stat_dispatch_cnt = r_stat_dispatch_cnt;
  assign bus.stat_stall_cnt    = r_stat_stall_cnt;
`else
  assign bus.stat_dispatch_cnt = '0;
  assign bus.stat_stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_csa_in_dispatch.sv
// Scoreboard bench for csa_in_dispatch: the stimulus pushes the expected
// dispatch (one-hot start, parameter, cycle) into a queue; an independent
// monitor pops and compares whenever calc_start is seen. A behavioural FIFO
// model serves read data one cycle after each pop.
module tb_csa_in_dispatch;

  localparam int W = 32;
  localparam int L = 160;
  localparam int N = 4;

  typedef struct {
    logic [N-1:0] start;
    logic [L-1:0] param;
    int           cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  exp_t         sb_q[$];
  logic [W-1:0] fifo_q[$];
  int           cyc   = 0;
  int           total = 0;
  int           bad   = 0;
  int           rr_m  = 0;

  csa_in_dispatch_if #(.AXI_DATA_WIDTH(W), .CSA_IN_PARAMETER_LENGTH(L), .CSA_CALC_INST_NUM(N)) bus ();

  csa_in_dispatch #(
    .AXI_DATA_WIDTH(W),
    .CSA_IN_PARAMETER_LENGTH(L),
    .CSA_CALC_INST_NUM(N)
  ) dut (
    .csa_calc_clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // edge counter: during the interval after edge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: first free instance from the model pointer upward, wrapping
  function automatic logic [N-1:0] model_pick(input logic [N-1:0] busy);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr_m + k) % N;
      if (!busy[idx]) begin
        rr_m = (idx + 1) % N;
        return N'(1 << idx);
      end
    end
    return '0;
  endfunction

  function automatic logic [L-1:0] rand_param();
    logic [L-1:0] p;
    for (int k = 0; k < L / W; k++) p[k*W +: W] = $urandom;
    return p;
  endfunction

  // FIFO model: data for a pop seen during a cycle appears just after the next edge
  initial begin
    logic popped;
    bus.csa_in_rdata = '0;
    forever begin
      @(negedge clk);
      popped = bus.csa_in_ren;
      @(posedge clk);
      #1;
      if (popped && fifo_q.size() > 0) bus.csa_in_rdata = fifo_q.pop_front();
    end
  end

  // Monitor: every start pulse must match the oldest expected dispatch
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.calc_start !== '0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_start", L'(bus.calc_start), '0);
        end else begin
          e = sb_q.pop_front();
          check("start_onehot", L'(bus.calc_start), L'(e.start));
          check("start_param", bus.calc_param, e.param);
          check("start_cycle", L'(cyc), L'(e.cyc));
        end
      end
    end
  end

  // One bulk: called in an IDLE cycle (#1 after an edge); returns #1 after the edge into the next IDLE
  task automatic run_bulk(input logic [L-1:0] p, input logic [N-1:0] busy_sel,
                          input int stall_len, input logic [N-1:0] busy_after);
    exp_t e;
    int   e0;
    bus.calc_busy = busy_sel;
    for (int k = 0; k < L / W; k++) fifo_q.push_back(p[k*W +: W]);
    e.start = model_pick((stall_len > 0) ? busy_after : busy_sel);
    e.param = p;
    bus.csa_in_r_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.csa_in_r_ready = 1'b0;
    e0    = cyc;
    e.cyc = e0 + 7 + stall_len;
    sb_q.push_back(e);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("ren_window", L'(bus.csa_in_ren), L'(k < 5));
    end
    @(negedge clk);
    check("stall_at_select", L'(bus.dispatch_stall), L'(stall_len > 0));
    if (stall_len > 0) begin
      repeat (stall_len - 1) @(negedge clk);
      check("stall_last_cycle", L'(bus.dispatch_stall), L'(1));
      @(posedge clk);
      #1;
      bus.calc_busy = busy_after;
      @(negedge clk);
      check("stall_released", L'(bus.dispatch_stall), L'(0));
    end
    while (cyc < e0 + 8 + stall_len) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [L-1:0] p;
    logic [N-1:0] b;
    int           e0;
    int           exp_disp;
    int           exp_stall;

    bus.csa_in_r_ready = 1'b1;
    bus.calc_busy      = '0;
    #1 rst_n = 1'b0;

    // Reset held with r_ready high: everything quiet
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ren", L'(bus.csa_in_ren), '0);
    check("rst_start", L'(bus.calc_start), '0);
    check("rst_stall", L'(bus.dispatch_stall), '0);
    check("rst_param", bus.calc_param, '0);
    check("rst_stat_disp", L'(bus.stat_dispatch_cnt), '0);
    check("rst_stat_stall", L'(bus.stat_stall_cnt), '0);
    bus.csa_in_r_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single bulk with the documented word pattern
    p = {32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    run_bulk(p, '0, 0, '0);

    // Mid-read reset: ren must drop at once; nothing dispatched afterwards
    for (int k = 0; k < L / W; k++) fifo_q.push_back($urandom);
    bus.csa_in_r_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.csa_in_r_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("ren_before_reset", L'(bus.csa_in_ren), L'(1));
    #2 rst_n = 1'b0;
    #1;
    check("ren_async_drop", L'(bus.csa_in_ren), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fifo_q.delete();
    rr_m = 0;
    repeat (15) @(posedge clk);
    #1;
    check("idle_after_reset_ren", L'(bus.csa_in_ren), '0);

    // Round robin: five back-to-back bulks with all instances free
    for (int i = 0; i < 5; i++) run_bulk(rand_param(), '0, 0, '0);

    // Stall: all busy for 20 cycles, then instance 2 frees up
    run_bulk(rand_param(), 4'b1111, 20, 4'b1011);

`ifdef CSA_IN_DISPATCH_STAT_EN
    exp_disp  = 6;
    exp_stall = 20;
`else
    exp_disp  = 0;
    exp_stall = 0;
`endif
    check("stat_dispatch_cnt", L'(bus.stat_dispatch_cnt), L'(exp_disp));
    check("stat_stall_cnt", L'(bus.stat_stall_cnt), L'(exp_stall));

    // Pointer now sits after instance 2: an all-free bulk goes to instance 3
    run_bulk(rand_param(), '0, 0, '0);

    // Randomized busy patterns, some with a stall before an instance frees
    for (int i = 0; i < 12; i++) begin
      b = N'($urandom_range(0, 14));
      if ($urandom_range(0, 3) == 0) run_bulk(rand_param(), 4'b1111, int'($urandom_range(1, 5)), b);
      else                           run_bulk(rand_param(), b, 0, b);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", L'(sb_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
